// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative multiply/divide unit with HI/LO registers.
// It runs a radix-2 shift-add multiply or a restoring divide on operand
// magnitudes, then fixes the signs in a final cycle. It requests an EX stall
// while busy if the instruction in EX needs the unit.
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_operand_a,
  input  logic [WIDTH-1:0] i_operand_b,
  input  logic             i_mthi,
  input  logic             i_mtlo,
  input  logic             i_read_hilo,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy,
  output logic             o_stall,
  output logic             o_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_accept;

  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic               r_div0;
  logic               r_neg_res;   // negate product / quotient
  logic               r_neg_rem;   // negate remainder (dividend was negative)
  logic [WIDTH-1:0]   r_a;         // multiplicand magnitude
  logic [WIDTH-1:0]   r_b;         // divisor magnitude
  logic [WIDTH-1:0]   r_raw_a;     // unmodified dividend, returned on divide by zero
  logic [2*WIDTH-1:0] r_acc;       // multiply: {partial product, remaining multiplier bits}
  logic [WIDTH:0]     r_rem;       // divide: partial remainder
  logic [WIDTH-1:0]   r_quo;       // divide: dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  // Operand conditioning: signed ops work on magnitudes, unsigned ops use raw values.
  logic             w_signed;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_b_zero;

  assign w_signed = ~i_op[0];
  assign w_mag_a  = (w_signed && i_operand_a[WIDTH-1]) ? -i_operand_a : i_operand_a;
  assign w_mag_b  = (w_signed && i_operand_b[WIDTH-1]) ? -i_operand_b : i_operand_b;
  assign w_b_zero = (i_operand_b == '0);

  // One shift-add step: add the multiplicand when the current multiplier bit is set.
  logic [WIDTH:0] w_mul_sum;
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_a : '0)};

  // One restoring step. The difference is one bit wider than the remainder
  // so its top bit is a clean borrow flag.
  logic [WIDTH+1:0] w_div_diff;
  logic             w_div_fits;
  assign w_div_diff = {r_rem, r_quo[WIDTH-1]} - {2'b00, r_b};
  assign w_div_fits = ~w_div_diff[WIDTH+1];

  // Final sign correction applied in FIXUP.
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  assign w_prod_fix = r_neg_res ? -r_acc : r_acc;
  assign w_quo_fix  = r_neg_res ? -r_quo : r_quo;
  assign w_rem_fix  = r_neg_rem ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks, so every register samples pre-edge values.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic and start acceptance; a flush overrides everything.
  always_comb begin
    // NOTE: defaults first so that every path assigns every output and no latch is inferred.
    w_next   = r_state;
    w_accept = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start && !i_flush) begin
          w_accept = 1'b1;
          w_next   = (i_op[1] && w_b_zero) ? S_FIXUP : S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == CNT_W'(WIDTH - 1)) w_next = S_FIXUP;
      end
      S_FIXUP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (i_flush) w_next = S_IDLE;
  end

  // Datapath: operand capture, iteration, sign fix-up, HI/LO writes and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the working registers are cleared along with the architectural ones, so an aborted op leaves nothing behind.
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_div0    <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_raw_a   <= '0;
      r_acc     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt     <= '0;
            r_is_div  <= i_op[1];
            r_div0    <= i_op[1] & w_b_zero;
            r_neg_res <= w_signed & (i_operand_a[WIDTH-1] ^ i_operand_b[WIDTH-1]);
            r_neg_rem <= w_signed & i_operand_a[WIDTH-1];
            r_a       <= w_mag_a;
            r_b       <= w_mag_b;
            r_raw_a   <= i_operand_a;
            r_acc     <= {{WIDTH{1'b0}}, w_mag_b};
            r_rem     <= '0;
            r_quo     <= w_mag_a;
          end else if (!i_flush && i_mthi) begin
            r_hi <= i_operand_a;
          end else if (!i_flush && i_mtlo) begin
            r_lo <= i_operand_a;
          end
        end
        S_CALC: begin
          if (!i_flush) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_is_div) begin
              r_rem <= w_div_fits ? w_div_diff[WIDTH:0] : {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
              r_quo <= {r_quo[WIDTH-2:0], w_div_fits};
            end else begin
              r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
            end
          end
        end
        S_FIXUP: begin
          if (!i_flush) begin
            r_done <= 1'b1;
            if (r_div0) begin
              r_hi <= r_raw_a;
              r_lo <= '1;
            end else if (r_is_div) begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end else begin
              r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
              r_lo <= w_prod_fix[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_hi    = r_hi;
  assign o_lo    = r_lo;
  assign o_busy  = (r_state != S_IDLE);
  assign o_stall = o_busy & (i_start | i_mthi | i_mtlo | i_read_hilo);
  assign o_done  = r_done;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Testbench for ex_muldiv_unit: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_ex_muldiv_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_start;
  logic [1:0]    i_op;
  logic [W-1:0]  i_operand_a;
  logic [W-1:0]  i_operand_b;
  logic          i_mthi;
  logic          i_mtlo;
  logic          i_read_hilo;
  logic          i_flush;
  logic [W-1:0]  o_hi;
  logic [W-1:0]  o_lo;
  logic          o_busy;
  logic          o_stall;
  logic          o_done;

  ex_muldiv_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_start     (i_start),
    .i_op        (i_op),
    .i_operand_a (i_operand_a),
    .i_operand_b (i_operand_b),
    .i_mthi      (i_mthi),
    .i_mtlo      (i_mtlo),
    .i_read_hilo (i_read_hilo),
    .i_flush     (i_flush),
    .o_hi        (o_hi),
    .o_lo        (o_lo),
    .o_busy      (o_busy),
    .o_stall     (o_stall),
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Expected architectural HI/LO contents.
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result {HI,LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'b00: res = sa * sb;
      2'b01: res = ua * ub;
      2'b10: begin
        if (b == '0) res = {a, 32'hFFFF_FFFF};
        else begin
          q   = sa / sb;
          r   = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == '0) res = {a, 32'hFFFF_FFFF};
        else begin
          ua  = ua / ub;
          ub  = {32'b0, a} % ub;
          res = {ub[31:0], ua[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h0000_0000;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h8000_0000;
      3:       v = 32'h0000_0001;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation and follow it to completion, checking latency,
  // busy length, result, stall behaviour and the single-cycle done pulse.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag, input bit hold_read, input bit poke_start);
    logic [63:0] exp;
    int cyc, busy_n, stall_bad, exp_lat;
    bit seen;
    exp       = ref_result(op, a, b);
    exp_lat   = (op[1] && b == '0) ? 2 : W + 2;
    i_start     = 1'b1;
    i_op        = op;
    i_operand_a = a;
    i_operand_b = b;
    i_read_hilo = hold_read;
    tick();
    i_start   = 1'b0;
    cyc       = 0;
    busy_n    = 0;
    stall_bad = 0;
    seen      = 1'b0;
    while (cyc < 100 && !seen) begin
      if (poke_start && cyc == 5) begin
        i_start     = 1'b1;
        i_op        = 2'b01;
        i_operand_a = $urandom;
        i_operand_b = $urandom;
      end
      if (poke_start && cyc == 8) i_start = 1'b0;
      #1;
      if (o_done) seen = 1'b1;
      else begin
        if (o_busy) busy_n++;
        if ((hold_read || i_start) && o_stall !== 1'b1) stall_bad++;
        tick();
        cyc++;
      end
    end
    i_start = 1'b0;
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_latency"}, 64'(cyc + 1), 64'(exp_lat));
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_lat - 1));
    check({tag, "_hilo"}, {o_hi, o_lo}, exp);
    check({tag, "_busy_at_done"}, 64'(o_busy), 64'd0);
    if (hold_read || poke_start) begin
      check({tag, "_stall_while_busy"}, 64'(stall_bad), 64'd0);
      check({tag, "_stall_at_done"}, 64'(o_stall), 64'd0);
    end
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    i_read_hilo = 1'b0;
    tick();
    check({tag, "_done_pulse_width"}, 64'(o_done), 64'd0);
  endtask

  // Start a MULT and kill it after at_cyc CALC cycles by flush or reset.
  task automatic abort_op(input bit use_reset, input int at_cyc, input string tag);
    int done_n;
    i_start     = 1'b1;
    i_op        = 2'b00;
    i_operand_a = $urandom;
    i_operand_b = $urandom;
    tick();
    i_start = 1'b0;
    repeat (at_cyc) tick();
    if (use_reset) reset = 1'b1;
    else           i_flush = 1'b1;
    tick();
    reset   = 1'b0;
    i_flush = 1'b0;
    if (use_reset) begin
      m_hi = '0;
      m_lo = '0;
    end
    check({tag, "_busy"}, 64'(o_busy), 64'd0);
    check({tag, "_done"}, 64'(o_done), 64'd0);
    check({tag, "_hilo"}, {o_hi, o_lo}, {m_hi, m_lo});
    done_n = 0;
    repeat (40) begin
      tick();
      if (o_done) done_n++;
    end
    check({tag, "_no_done_later"}, 64'(done_n), 64'd0);
    check({tag, "_hilo_later"}, {o_hi, o_lo}, {m_hi, m_lo});
  endtask

  initial begin
    reset       = 1'b1;
    i_start     = 1'b0;
    i_op        = 2'b00;
    i_operand_a = '0;
    i_operand_b = '0;
    i_mthi      = 1'b0;
    i_mtlo      = 1'b0;
    i_read_hilo = 1'b0;
    i_flush     = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    check("reset_hilo", {o_hi, o_lo}, 64'd0);
    check("reset_busy", 64'(o_busy), 64'd0);
    check("reset_done", 64'(o_done), 64'd0);
    check("reset_stall", 64'(o_stall), 64'd0);

    // Directed arithmetic corners.
    run_op(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, "mult_m2x3", 1'b0, 1'b0);
    check("mult_m2x3_value", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 1'b0, 1'b0);
    check("multu_max_value", {m_hi, m_lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, "div_m7_2", 1'b0, 1'b0);
    check("div_m7_2_value", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b0, 1'b0);
    check("div_ovf_value", {m_hi, m_lo}, 64'h0000_0000_8000_0000);
    run_op(2'b11, 32'd100, 32'd0, "divu_by0", 1'b0, 1'b0);
    check("divu_by0_value", {m_hi, m_lo}, 64'h0000_0064_FFFF_FFFF);
    run_op(2'b10, 32'hFFFF_FF9C, 32'd0, "div_by0", 1'b0, 1'b0);

    // Stall protocol.
    run_op(2'b00, 32'h1234_5678, 32'hFFFF_0001, "mult_read_stall", 1'b1, 1'b0);
    run_op(2'b11, 32'hDEAD_BEEF, 32'h0000_1234, "divu_second_start", 1'b0, 1'b1);

    // MTHI / MTLO on consecutive cycles, then a simultaneous pair.
    i_mthi      = 1'b1;
    i_operand_a = 32'h1234_5678;
    #1;
    check("mthi_no_stall", 64'(o_stall), 64'd0);
    tick();
    i_mthi = 1'b0;
    m_hi   = 32'h1234_5678;
    check("mthi_hi", 64'(o_hi), 64'(m_hi));
    check("mthi_lo_kept", 64'(o_lo), 64'(m_lo));
    i_mtlo      = 1'b1;
    i_operand_a = 32'h9ABC_DEF0;
    tick();
    i_mtlo = 1'b0;
    m_lo   = 32'h9ABC_DEF0;
    check("mtlo_hilo", {o_hi, o_lo}, {m_hi, m_lo});
    check("mtlo_busy", 64'(o_busy), 64'd0);
    i_mthi      = 1'b1;
    i_mtlo      = 1'b1;
    i_operand_a = 32'h0BAD_F00D;
    tick();
    i_mthi = 1'b0;
    i_mtlo = 1'b0;
    m_hi   = 32'h0BAD_F00D;
    check("mthi_over_mtlo", {o_hi, o_lo}, {m_hi, m_lo});

    // A flush in the start cycle blocks acceptance.
    i_start     = 1'b1;
    i_flush     = 1'b1;
    i_op        = 2'b01;
    i_operand_a = 32'd5;
    i_operand_b = 32'd7;
    tick();
    i_start = 1'b0;
    i_flush = 1'b0;
    check("flush_blocks_start", 64'(o_busy), 64'd0);

    // Aborts, each followed by a fresh MULT.
    abort_op(1'b0, 10, "flush_calc10");
    run_op(2'b00, 32'h7FFF_FFFF, 32'h8000_0000, "mult_after_flush", 1'b0, 1'b0);
    abort_op(1'b1, 20, "reset_calc20");
    run_op(2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFF9, "mult_after_reset", 1'b0, 1'b0);

    // Randomized operations.
    for (int k = 0; k < 30; k++) begin
      logic [1:0] op;
      logic [W-1:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = pick_operand();
      b  = pick_operand();
      run_op(op, a, b, $sformatf("rand%0d_op%0d", k, op), 1'(k % 5 == 0), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative multiply/divide unit with its own sequencer and HI/LO register pair. It sits beside the EX stage and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. MFHI and MFLO read its HI/LO outputs. While a computation is in flight, it raises a stall request to the hazard logic whenever the instruction in EX needs the unit.

## Interface
- WIDTH, 32, operand/HI/LO width; must be a power of two ≥ 8
- CNT_W, $clog2(WIDTH)+1, iteration counter width
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- i_start  in  1  EX holds a MULT/MULTU/DIV/DIVU this cycle
- i_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- i_operand_a  in  WIDTH  rs value, already forwarded (dividend / multiplicand)
- i_operand_b  in  WIDTH  rt value, already forwarded (divisor / multiplier)
- i_mthi  in  1  EX holds MTHI
- i_mtlo  in  1  EX holds MTLO
- i_read_hilo  in  1  EX holds MFHI or MFLO
- i_flush  in  1  kill the in-flight operation (branch/jump flush of its originating slot)
- o_hi  out  WIDTH  HI register
- o_lo  out  WIDTH  LO register
- o_busy  out  1  state ≠ IDLE
- o_stall  out  1  combinational: o_busy & (i_start | i_mthi | i_mtlo | i_read_hilo)
- o_done  out  1  one-cycle pulse: HI/LO just updated by a mult/div

## Operation
- States: IDLE, CALC, FIXUP.
- IDLE, i_start=1:
  - latch |a| and |b| (magnitudes only for signed ops; raw values for unsigned ops)
  - latch result sign, and dividend sign for the remainder
  - counter ← 0
  - next state CALC; if a divide has b=0, next state FIXUP
- CALC, multiply: radix-2 shift-add, one multiplier bit per cycle into a 2·WIDTH accumulator.
- CALC, divide: restoring, one quotient bit per cycle; remainder register WIDTH+1 bits.
- CALC exit: after WIDTH iterations (counter = WIDTH−1), go to FIXUP.
- FIXUP:
  - apply two's-complement negation where needed
  - multiply: product sign = sa^sb
  - divide: quotient sign = sa^sb; remainder sign = sign of dividend
  - write HI/LO, then go to IDLE
- Results:
  - MULT/MULTU: {HI,LO} = full 2·WIDTH product
  - DIV/DIVU: LO = quotient truncated toward zero, HI = remainder
- Divide by zero: HI = a (raw), LO = all ones. No iterations are run.
- Signed overflow: 0x80000000 / −1 gives LO = 0x80000000, HI = 0. This falls out of the magnitude path with no special case.
- MTHI/MTLO in IDLE: HI (or LO) ← i_operand_a at the next edge. The other register is unchanged.
- Priority in IDLE: i_start > i_mthi > i_mtlo. Lower-priority requests in the same cycle are ignored.
- Any request while busy is not accepted. o_stall holds EX, and the instruction is re-presented until the unit reaches IDLE.
- i_flush, any state: go to IDLE next edge. HI/LO keep their pre-operation values, and o_done is not pulsed.
- i_flush has priority over i_start in the same cycle: the start is not accepted.
- Reset, including mid-operation:
  - state IDLE, counter 0
  - o_hi = o_lo = 0, o_busy = 0, o_done = 0
  - internal accumulators cleared

## Timing
- Edge N, IDLE with i_start: operands latched; o_busy = 1 from cycle N+1.
- Cycles N+1 .. N+WIDTH: CALC (32 cycles for WIDTH=32).
- Cycle N+WIDTH+1: FIXUP; HI/LO written at its closing edge.
- Cycle N+WIDTH+2: o_busy = 0, o_done = 1, new o_hi/o_lo visible. A pending MFHI/MFLO in EX sees the new value and proceeds this cycle.
- Total start-to-result latency: WIDTH+2 cycles (34).
- Divide by zero: FIXUP at N+1; result and o_done at N+2.
- MTHI/MTLO: value visible on o_hi/o_lo in the cycle after acceptance. A back-to-back MFHI needs no stall; EX forwarding covers that.
- o_done is registered and asserted for exactly one cycle per completed operation.
- o_stall is combinational from o_busy and the request inputs. It has no combinational path from the operand data.

## Test plan
- MULT a=0xFFFFFFFE (−2), b=0x00000003 → after 34 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFA. o_done pulses once, o_busy is high for exactly 33 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV cases:
  - a=−7, b=2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1)
  - a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0
  - DIVU a=100, b=0 → HI=100, LO=0xFFFFFFFF, o_done at cycle N+2
- Stall protocol:
  - i_read_hilo held high during a MULT → o_stall high every busy cycle and low in the o_done cycle, when o_lo holds the product
  - second i_start during CALC → not accepted, and the first result is correct
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles → o_hi, o_lo update one cycle after each; o_busy stays 0.
- Abort cases:
  - i_flush at CALC cycle 10 → IDLE next cycle, HI/LO unchanged, no o_done
  - reset at CALC cycle 20 → HI=LO=0, o_busy=0
  - a new MULT right after either abort completes correctly
